// File: rtl/ht_responder.sv
// Key/value hash-table responder: insert, delete and search over an open-addressed table
// with linear probing, one slot examined per cycle.
module ht_responder #(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned VALUE_WIDTH = 32,
    parameter int unsigned TABLE_SIZE  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic [1:0]             op_sel,
    input  logic                   op_en,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   op_done,
    output logic                   op_error,
    output logic [3:0]             collision_count
);

    localparam int unsigned IdxW     = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
    localparam int unsigned NumBytes = (KEY_WIDTH + 7) / 8;
    localparam logic [IdxW-1:0] KLast = IdxW'(TABLE_SIZE - 1);

    localparam logic [1:0] OpInsert = 2'b00;
    localparam logic [1:0] OpDelete = 2'b01;
    localparam logic [1:0] OpSearch = 2'b10;

    typedef enum logic [1:0] {SlotEmpty, SlotValid, SlotTomb} slot_e;
    typedef enum logic [1:0] {StIdle, StProbe, StDone} state_e;

    // XOR-fold the key into one byte (zero-padded), keep the low index bits.
    function automatic logic [IdxW-1:0] hash_idx(input logic [KEY_WIDTH-1:0] key);
        logic [NumBytes*8-1:0] padded;
        logic [7:0]            fold;
        padded = (NumBytes*8)'(key);
        fold   = '0;
        for (int b = 0; b < int'(NumBytes); b++) begin
            fold = fold ^ padded[b*8 +: 8];
        end
        return fold[IdxW-1:0];
    endfunction

    state_e                 state_q;
    slot_e                  slot_q    [TABLE_SIZE];
    logic [KEY_WIDTH-1:0]   key_mem_q [TABLE_SIZE];
    logic [VALUE_WIDTH-1:0] val_mem_q [TABLE_SIZE];

    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [1:0]             op_q;
    logic [IdxW-1:0]        h_q;
    logic [IdxW-1:0]        k_q;
    logic                   tomb_seen_q;
    logic [IdxW-1:0]        tomb_idx_q;

    logic [VALUE_WIDTH-1:0] value_out_q;
    logic                   op_done_q;
    logic                   op_error_q;
    logic [3:0]             coll_q;

    logic [IdxW-1:0] slot_idx;
    slot_e           cur_state;
    logic            key_match;
    logic            decide;
    logic            ins_ok;
    logic [IdxW-1:0] ins_idx;
    logic [3:0]      coll_sat;

    // Examine the current probe slot and work out the decision and insert target.
    always_comb begin
        slot_idx  = h_q + k_q;
        cur_state = slot_q[slot_idx];
        key_match = (cur_state == SlotValid) && (key_mem_q[slot_idx] == key_q);
        decide    = key_match || (cur_state == SlotEmpty) || (k_q == KLast);
        coll_sat  = (32'(k_q) > 32'd15) ? 4'd15 : 4'(k_q);

        ins_ok  = 1'b1;
        ins_idx = slot_idx;
        if (key_match) begin
            ins_idx = slot_idx;
        end else if (tomb_seen_q) begin
            ins_idx = tomb_idx_q;
        end else if (cur_state == SlotTomb || cur_state == SlotEmpty) begin
            // A tomb here is only reached as a decision on the final probe.
            ins_idx = slot_idx;
        end else begin
            ins_ok = 1'b0;
        end
    end

    // Control FSM, table updates and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            val_q       <= '0;
            op_q        <= '0;
            h_q         <= '0;
            k_q         <= '0;
            tomb_seen_q <= 1'b0;
            tomb_idx_q  <= '0;
            value_out_q <= '0;
            op_done_q   <= 1'b0;
            op_error_q  <= 1'b0;
            coll_q      <= '0;
            for (int i = 0; i < int'(TABLE_SIZE); i++) begin
                slot_q[i]    <= SlotEmpty;
                key_mem_q[i] <= '0;
                val_mem_q[i] <= '0;
            end
        end else begin
            op_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (op_en) begin
                        key_q       <= key_in;
                        val_q       <= value_in;
                        op_q        <= op_sel;
                        h_q         <= hash_idx(key_in);
                        k_q         <= '0;
                        tomb_seen_q <= 1'b0;
                        if (op_sel == 2'b11) begin
                            state_q     <= StDone;
                            op_done_q   <= 1'b1;
                            op_error_q  <= 1'b1;
                            value_out_q <= '0;
                            coll_q      <= '0;
                        end else begin
                            state_q <= StProbe;
                        end
                    end
                end
                StProbe: begin
                    if (decide) begin
                        state_q     <= StDone;
                        op_done_q   <= 1'b1;
                        coll_q      <= coll_sat;
                        value_out_q <= '0;
                        op_error_q  <= 1'b1;
                        if (op_q == OpSearch) begin
                            if (key_match) begin
                                value_out_q <= val_mem_q[slot_idx];
                                op_error_q  <= 1'b0;
                            end
                        end else if (op_q == OpDelete) begin
                            if (key_match) begin
                                slot_q[slot_idx] <= SlotTomb;
                                op_error_q       <= 1'b0;
                            end
                        end else if (op_q == OpInsert) begin
                            if (ins_ok) begin
                                slot_q[ins_idx]    <= SlotValid;
                                key_mem_q[ins_idx] <= key_q;
                                val_mem_q[ins_idx] <= val_q;
                                op_error_q         <= 1'b0;
                            end
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                        // Remember only the first tomb; inserts prefer the earliest free slot.
                        if (op_q == OpInsert && !tomb_seen_q && cur_state == SlotTomb) begin
                            tomb_seen_q <= 1'b1;
                            tomb_idx_q  <= slot_idx;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign value_out       = value_out_q;
    assign op_done         = op_done_q;
    assign op_error        = op_error_q;
    assign collision_count = coll_q;

endmodule

// File: tb/tb_ht_responder.sv
// Directed bench for ht_responder: expected results are queued when an op is issued
// and compared when op_done appears.
module tb_ht_responder;

    logic        clk;
    logic        rst;
    logic [31:0] key_in;
    logic [31:0] value_in;
    logic [1:0]  op_sel;
    logic        op_en;
    logic [31:0] value_out;
    logic        op_done;
    logic        op_error;
    logic [3:0]  collision_count;

    ht_responder #(
        .KEY_WIDTH  (32),
        .VALUE_WIDTH(32),
        .TABLE_SIZE (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .value_in       (value_in),
        .op_sel         (op_sel),
        .op_en          (op_en),
        .value_out      (value_out),
        .op_done        (op_done),
        .op_error       (op_error),
        .collision_count(collision_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        err;
        logic [3:0]  coll;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, wait (bounded) for op_done, compare against the queued entry.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] key,
                         input logic [31:0] val, input logic [31:0] e_val, input logic e_err,
                         input logic [3:0] e_coll, input int e_lat);
        exp_t e;
        exp_t got;
        int   cyc;
        e.value = e_val;
        e.err   = e_err;
        e.coll  = e_coll;
        e.lat   = e_lat;
        sb_q.push_back(e);
        op_sel   = op;
        key_in   = key;
        value_in = val;
        op_en    = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        cyc   = 1;
        while (!op_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        got = sb_q.pop_front();
        check({tag, "_done"}, 64'(op_done), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(got.lat));
        check({tag, "_value"}, 64'(value_out), 64'(got.value));
        check({tag, "_err"}, 64'(op_error), 64'(got.err));
        check({tag, "_coll"}, 64'(collision_count), 64'(got.coll));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(op_done), 64'd0);
    endtask

    int seen;

    initial begin
        rst      = 1'b0;
        key_in   = '0;
        value_in = '0;
        op_sel   = '0;
        op_en    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_value", 64'(value_out), 64'd0);
        check("rst_done", 64'(op_done), 64'd0);
        check("rst_err", 64'(op_error), 64'd0);
        check("rst_coll", 64'(collision_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("search_empty", 2'b10, 32'h5, 32'h0, 32'h0, 1'b1, 4'd0, 2);
        do_op("ins_1", 2'b00, 32'h1, 32'hAAAA0001, 32'h0, 1'b0, 4'd0, 2);
        do_op("srch_1", 2'b10, 32'h1, 32'h0, 32'hAAAA0001, 1'b0, 4'd0, 2);
        do_op("ins_11", 2'b00, 32'h11, 32'hBBBB0011, 32'h0, 1'b0, 4'd1, 3);
        do_op("ins_21", 2'b00, 32'h21, 32'hCCCC0021, 32'h0, 1'b0, 4'd2, 4);
        do_op("srch_21", 2'b10, 32'h21, 32'h0, 32'hCCCC0021, 1'b0, 4'd2, 4);
        do_op("del_11", 2'b01, 32'h11, 32'h0, 32'h0, 1'b0, 4'd1, 3);
        do_op("srch_21b", 2'b10, 32'h21, 32'h0, 32'hCCCC0021, 1'b0, 4'd2, 4);
        // Probes past the tomb at slot 2 to the empty slot 4, then writes into the tomb.
        do_op("ins_31", 2'b00, 32'h31, 32'hBEEF, 32'h0, 1'b0, 4'd3, 5);
        do_op("srch_31", 2'b10, 32'h31, 32'h0, 32'hBEEF, 1'b0, 4'd1, 3);
        do_op("srch_11", 2'b10, 32'h11, 32'h0, 32'h0, 1'b1, 4'd3, 5);

        // Clean table for the fill test.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("fill_%0d", i), 2'b00, 32'(i), 32'h1000 + 32'(i), 32'h0, 1'b0,
                  4'd0, 2);
        end
        do_op("ins_full", 2'b00, 32'h10, 32'hDEAD, 32'h0, 1'b1, 4'd15, 17);
        do_op("ins_upd5", 2'b00, 32'h5, 32'h5555, 32'h0, 1'b0, 4'd0, 2);
        do_op("srch_5", 2'b10, 32'h5, 32'h0, 32'h5555, 1'b0, 4'd0, 2);
        do_op("illegal", 2'b11, 32'h7, 32'h0, 32'h0, 1'b1, 4'd0, 1);
        do_op("srch_miss_full", 2'b10, 32'h10, 32'h0, 32'h0, 1'b1, 4'd15, 17);
        do_op("srch_7", 2'b10, 32'h7, 32'h0, 32'h1007, 1'b0, 4'd0, 2);

        // Abort a long search with reset part-way through probing.
        op_sel = 2'b10;
        key_in = 32'h10;
        op_en  = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_value", 64'(value_out), 64'd0);
        check("abort_done", 64'(op_done), 64'd0);
        check("abort_err", 64'(op_error), 64'd0);
        check("abort_coll", 64'(collision_count), 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        do_op("srch_3_after_rst", 2'b10, 32'h3, 32'h0, 32'h0, 1'b1, 4'd0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
